// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared types and constants for the code-lock controller.
//                Holds the controller state encoding and the BCD digit
//                constants used by the digit-entry path.
//  Contents    : state_e   - controller states
//                BCD_W     - width of one BCD digit
//                DIGIT_MAX - largest decimal digit value
//  Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int BCD_W     = 4;
    localparam int DIGIT_MAX = 9;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } state_e;

endpackage : lock_pkg
`default_nettype wire

// File: rtl/lock_ctrl_modcnt.sv
`default_nettype none
// ============================================================================
//  Module      : lock_ctrl_modcnt
//  Description : Parameterised modulo counter. Counts 0..i_max on each
//                enabled cycle and wraps back to 0 after i_max. The clear
//                input is synchronous and overrides the count enable.
//  Ports       : clk    - clock
//                i_clr  - synchronous clear (active high, highest priority)
//                i_ce   - count enable
//                i_max  - terminal value (modulus - 1), may change at run time
//                o_q    - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_ctrl_modcnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_ce) begin
            // Use >= so a count that is already past a freshly lowered
            // terminal value still wraps instead of running to all-ones.
            if (r_q >= i_max) begin
                r_q <= '0;
            end else begin
                r_q <= r_q + WIDTH'(1);
            end
        end
    end

    assign o_q = r_q;

endmodule : lock_ctrl_modcnt
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lock_ctrl
//  Description : Sequencing controller for the code lock. Collects a
//                DIGITS-long BCD code from debounced push-button pulses,
//                compares it against the stored code and holds the lock
//                open, in error or in lockout for a fixed number of
//                timebase ticks. The stored code can be reprogrammed while
//                the lock is open.
//  Ports       : clk        - system clock
//                clr_n      - synchronous active-low reset
//                tick       - one-cycle timebase strobe
//                btn_up     - pulse, increment current digit (mod 10)
//                btn_enter  - pulse, commit digit / close lock
//                btn_prog   - pulse, enter programming (only while open)
//                digit      - currently selected digit 0..9
//                digit_idx  - position of the digit being entered
//                unlocked   - lock actuator, high while open or programming
//                error      - high while showing a wrong-code indication
//                locked_out - high during lockout after repeated failures
//                prog       - high while programming a new code
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                      DIGITS       = 4,
    parameter int                      IDX_W        = 2,
    parameter logic [BCD_W*DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      OPEN_TICKS   = 5,
    parameter int                      ERR_TICKS    = 2,
    parameter int                      LOCK_TICKS   = 10,
    parameter int                      TMR_W        = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tick,
    input  logic             btn_up,
    input  logic             btn_enter,
    input  logic             btn_prog,
    output logic [BCD_W-1:0] digit,
    output logic [IDX_W-1:0] digit_idx,
    output logic             unlocked,
    output logic             error,
    output logic             locked_out,
    output logic             prog
);

    // The failure counter never holds MAX_FAIL itself: reaching it sends the
    // FSM to lockout and clears the counter in the same edge.
    localparam int FAIL_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
    localparam int CODE_W = BCD_W * DIGITS;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [CODE_W-1:0]   r_entry;
    logic [CODE_W-1:0]   r_code;
    logic [FAIL_W-1:0]   r_fail;

    logic [FAIL_W-1:0]   w_fail_nxt;
    logic                w_code_load;
    logic [CODE_W-1:0]   w_entry_nxt;

    logic [BCD_W-1:0]    w_digit;
    logic [TMR_W-1:0]    w_tmr;
    logic [TMR_W-1:0]    w_tmr_max;

    logic                w_in_entry;
    logic                w_commit;
    logic                w_last;
    logic                w_timed;
    logic                w_expire;
    logic                w_transition;

    // ------------------------------------------------------------------------
    // Decodes of the current state and button activity
    // ------------------------------------------------------------------------
    assign w_in_entry   = (r_state == ST_ENTRY) || (r_state == ST_PROG);
    assign w_commit     = btn_enter && w_in_entry;
    assign w_last       = (r_idx == IDX_W'(DIGITS - 1));
    assign w_timed      = (r_state == ST_OPEN) || (r_state == ST_ERROR) ||
                          (r_state == ST_LOCKOUT);
    assign w_expire     = tick && w_timed && (w_tmr == w_tmr_max);
    assign w_transition = (w_state_nxt != r_state);

    // Terminal timer value for the state currently being timed.
    always_comb begin
        w_tmr_max = '0;
        case (r_state)
            ST_OPEN:    w_tmr_max = TMR_W'(OPEN_TICKS - 1);
            ST_ERROR:   w_tmr_max = TMR_W'(ERR_TICKS - 1);
            ST_LOCKOUT: w_tmr_max = TMR_W'(LOCK_TICKS - 1);
            default:    w_tmr_max = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Digit select counter (0..9). Enter wins over up in the same cycle so
    // the committed value is always the pre-increment digit.
    // ------------------------------------------------------------------------
    lock_ctrl_modcnt #(
        .WIDTH (BCD_W)
    ) u_digit_cnt (
        .clk   (clk),
        .i_clr (!clr_n || btn_enter || w_transition),
        .i_ce  (btn_up && !btn_enter && w_in_entry),
        .i_max (BCD_W'(DIGIT_MAX)),
        .o_q   (w_digit)
    );

    // ------------------------------------------------------------------------
    // State timer: counts ticks in the timed states, restarts on every
    // state change so each state sees a fresh count from zero.
    // ------------------------------------------------------------------------
    lock_ctrl_modcnt #(
        .WIDTH (TMR_W)
    ) u_state_tmr (
        .clk   (clk),
        .i_clr (!clr_n || w_transition),
        .i_ce  (tick && w_timed),
        .i_max (w_tmr_max),
        .o_q   (w_tmr)
    );

    // ------------------------------------------------------------------------
    // Entry buffer with the current digit merged in. Digit 0 lives in the
    // most significant nibble. The merged value also feeds the code register
    // so a programming pass stores the digit committed on its final edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_entry_nxt = r_entry;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_entry_nxt[BCD_W*(DIGITS-1-i) +: BCD_W] = w_digit;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail;
        w_code_load = 1'b0;
        case (r_state)
            ST_ENTRY: begin
                if (w_commit && w_last) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_entry == r_code) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = ST_OPEN;
                end else if ((int'(r_fail) + 1) == MAX_FAIL) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = ST_LOCKOUT;
                end else begin
                    w_fail_nxt  = r_fail + FAIL_W'(1);
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_OPEN: begin
                // Buttons beat the timeout; prog beats enter.
                if (btn_prog) begin
                    w_state_nxt = ST_PROG;
                end else if (btn_enter || w_expire) begin
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_ERROR, ST_LOCKOUT: begin
                if (w_expire) begin
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_PROG: begin
                if (w_commit && w_last) begin
                    w_code_load = 1'b1;
                    w_state_nxt = ST_ENTRY;
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= ST_ENTRY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_idx <= '0;
        end else if (w_transition) begin
            r_idx <= '0;
        end else if (w_commit) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_entry <= '0;
        end else if (w_commit) begin
            r_entry <= w_entry_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_code <= DEFAULT_CODE;
        end else if (w_code_load) begin
            r_code <= w_entry_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_fail <= '0;
        end else begin
            r_fail <= w_fail_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registered state
    // ------------------------------------------------------------------------
    assign digit      = w_digit;
    assign digit_idx  = r_idx;
    assign unlocked   = (r_state == ST_OPEN) || (r_state == ST_PROG);
    assign error      = (r_state == ST_ERROR);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign prog       = (r_state == ST_PROG);

endmodule : lock_ctrl
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_ctrl
//  Description : Directed self-checking bench for lock_ctrl with default
//                parameters (code 1234, 3 failures, 5/2/10 tick timers).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       tick;
    logic       btn_up;
    logic       btn_enter;
    logic       btn_prog;
    logic [3:0] digit;
    logic [1:0] digit_idx;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic       prog;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lock_ctrl #(
        .DIGITS       (4),
        .IDX_W        (2),
        .DEFAULT_CODE (16'h1234),
        .MAX_FAIL     (3),
        .OPEN_TICKS   (5),
        .ERR_TICKS    (2),
        .LOCK_TICKS   (10),
        .TMR_W        (8)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .tick       (tick),
        .btn_up     (btn_up),
        .btn_enter  (btn_enter),
        .btn_prog   (btn_prog),
        .digit      (digit),
        .digit_idx  (digit_idx),
        .unlocked   (unlocked),
        .error      (error),
        .locked_out (locked_out),
        .prog       (prog)
    );

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            btn_up = 1'b1;
            step();
            btn_up = 1'b0;
        end
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        step();
        btn_enter = 1'b0;
    endtask

    task automatic press_prog();
        btn_prog = 1'b1;
        step();
        btn_prog = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic enter_digit(input int d);
        press_up(d);
        press_enter();
    endtask

    // Enter four digits, then spend the CHECK cycle; result state follows.
    task automatic try_code(input int a, input int b, input int c, input int d);
        enter_digit(a);
        enter_digit(b);
        enter_digit(c);
        enter_digit(d);
        step();
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, 32'({unlocked, error, locked_out, prog}), 32'(exp));
    endtask

    initial begin
        clr_n = 1'b0; tick = 1'b0; btn_up = 1'b0; btn_enter = 1'b0; btn_prog = 1'b0;
        step();
        step();
        chk("rst_digit", 32'(digit), 0);
        chk("rst_idx", 32'(digit_idx), 0);
        chk_flags("rst_flags", 4'b0000);
        clr_n = 1'b1;
        step();

        // --- Correct default code, CHECK lasts one cycle, open for 5 ticks
        press_up(3);
        chk("up3_digit", 32'(digit), 3);
        press_enter();
        chk("enter_idx", 32'(digit_idx), 1);
        chk("enter_digit_clr", 32'(digit), 0);
        // first digit committed 3; restart cleanly via reset-free path:
        // complete with 234 -> code 3234 mismatches, so use a fresh reset.
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        enter_digit(1);
        enter_digit(2);
        enter_digit(3);
        enter_digit(4);
        chk_flags("check_cycle", 4'b0000);
        step();
        chk_flags("open", 4'b1000);
        wait_ticks(4);
        chk_flags("open_4ticks", 4'b1000);
        wait_ticks(1);
        chk_flags("open_expired", 4'b0000);
        chk("after_open_digit", 32'(digit), 0);
        chk("after_open_idx", 32'(digit_idx), 0);

        // --- tick ignored in ENTRY, wrap 9->0, enter beats up
        tick = 1'b1;
        press_up(1);
        tick = 1'b0;
        chk("tick_entry_digit", 32'(digit), 1);
        press_up(10);
        chk("wrap_digit", 32'(digit), 1);
        btn_up = 1'b1;
        btn_enter = 1'b1;
        step();
        btn_up = 1'b0;
        btn_enter = 1'b0;
        chk("upenter_digit", 32'(digit), 0);
        chk("upenter_idx", 32'(digit_idx), 1);
        enter_digit(2);
        enter_digit(3);
        enter_digit(4);
        step();
        chk_flags("upenter_open", 4'b1000);
        press_enter();
        chk_flags("enter_closes", 4'b0000);

        // --- Three wrong codes: error, error, lockout
        try_code(0, 0, 0, 0);
        chk_flags("wrong1", 4'b0100);
        wait_ticks(1);
        chk_flags("wrong1_1tick", 4'b0100);
        wait_ticks(1);
        chk_flags("wrong1_done", 4'b0000);
        try_code(0, 0, 0, 0);
        chk_flags("wrong2", 4'b0100);
        wait_ticks(2);
        chk_flags("wrong2_done", 4'b0000);
        try_code(0, 0, 0, 0);
        chk_flags("wrong3_lockout", 4'b0010);
        press_up(1);
        chk("lockout_up_ignored", 32'(digit), 0);
        press_enter();
        chk("lockout_enter_ignored", 32'(digit_idx), 0);
        press_prog();
        chk_flags("lockout_prog_ignored", 4'b0010);
        wait_ticks(9);
        chk_flags("lockout_9ticks", 4'b0010);
        wait_ticks(1);
        chk_flags("lockout_done", 4'b0000);
        try_code(1, 2, 3, 4);
        chk_flags("after_lockout_open", 4'b1000);
        press_enter();

        // --- Fail, succeed, then two fails give only ERROR
        try_code(0, 0, 0, 0);
        chk_flags("fs_wrong", 4'b0100);
        wait_ticks(2);
        try_code(1, 2, 3, 4);
        chk_flags("fs_open", 4'b1000);
        press_enter();
        try_code(0, 0, 0, 0);
        chk_flags("fs_wrong_a", 4'b0100);
        wait_ticks(2);
        try_code(0, 0, 0, 0);
        chk_flags("fs_wrong_b_not_lockout", 4'b0100);
        wait_ticks(2);

        // --- Programming a new code 9876
        try_code(1, 2, 3, 4);
        chk_flags("prog_open", 4'b1000);
        press_prog();
        chk_flags("prog_mode", 4'b1001);
        chk("prog_idx", 32'(digit_idx), 0);
        enter_digit(9);
        enter_digit(8);
        enter_digit(7);
        enter_digit(6);
        chk_flags("prog_done", 4'b0000);
        chk("prog_done_idx", 32'(digit_idx), 0);
        try_code(1, 2, 3, 4);
        chk_flags("old_code_errors", 4'b0100);
        wait_ticks(2);
        try_code(9, 8, 7, 6);
        chk_flags("new_code_opens", 4'b1000);

        // --- Reset mid-programming discards partial code, restores 1234
        press_prog();
        enter_digit(5);
        enter_digit(5);
        chk("midprog_idx", 32'(digit_idx), 2);
        clr_n = 1'b0;
        step();
        chk_flags("midprog_rst_flags", 4'b0000);
        chk("midprog_rst_idx", 32'(digit_idx), 0);
        chk("midprog_rst_digit", 32'(digit), 0);
        clr_n = 1'b1;
        try_code(9, 8, 7, 6);
        chk_flags("reverted_9876_errors", 4'b0100);
        wait_ticks(2);
        try_code(1, 2, 3, 4);
        chk_flags("reverted_1234_opens", 4'b1000);
        press_enter();
        chk_flags("final_close", 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_lock_ctrl
`default_nettype wire
